// File: rtl/cmsdk_ahb_eg_slave_arb_pkg.sv
// Shared definitions for the example-slave register-port arbiter:
// FSM state encoding, requester index type and register-port idle values.
package cmsdk_ahb_eg_slave_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } arb_state_t;

    localparam int REQ_IDX_W = 1;
    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    localparam req_idx_t REQ_IDX_0 = req_idx_t'(0);
    localparam req_idx_t REQ_IDX_1 = req_idx_t'(1);

    localparam logic        REG_EN_DFLT    = 1'b0;
    localparam logic [3:0]  REG_STRB_DFLT  = 4'b0000;
    localparam logic [31:0] REG_WDATA_DFLT = 32'h0000_0000;
    localparam logic [31:0] RDATA_DFLT     = 32'h0000_0000;

endpackage

// File: rtl/cmsdk_ahb_eg_slave_arb_rr.sv
// Two-way grant selector for the register-port arbiter.
// Default build: round-robin on contention, tracked by a last_gnt register.
// With CMSDK_AHB_EG_SLAVE_ARB_FIXED_PRIO_EN defined: requester 0 always wins
// contention and the last_gnt register (and its clock/reset/update ports) is gone.
module cmsdk_ahb_eg_slave_arb_rr
    import cmsdk_ahb_eg_slave_arb_pkg::*;
(
`ifndef CMSDK_AHB_EG_SLAVE_ARB_FIXED_PRIO_EN
    input  logic     hclk,
    input  logic     hresetn,
    input  logic     update,
`endif
    input  logic     req0,
    input  logic     req1,
    output req_idx_t gnt_idx
);

`ifdef CMSDK_AHB_EG_SLAVE_ARB_FIXED_PRIO_EN

    // Requester 1 is chosen only when requester 0 is not asking
    always_comb begin
        gnt_idx = REQ_IDX_0;
        if (!req0 && req1) begin
            gnt_idx = REQ_IDX_1;
        end
    end

`else

    req_idx_t last_gnt;

    // On contention the requester that was not served last wins
    always_comb begin
        gnt_idx = REQ_IDX_0;
        if (req0 && req1) begin
            gnt_idx = (last_gnt == REQ_IDX_0) ? REQ_IDX_1 : REQ_IDX_0;
        end else if (req1) begin
            gnt_idx = REQ_IDX_1;
        end
    end

    // Remember each taken grant; reset value makes requester 0 win first
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            last_gnt <= REQ_IDX_1;
        end else if (update) begin
            last_gnt <= gnt_idx;
        end
    end

`endif

endmodule

// File: rtl/cmsdk_ahb_eg_slave_arb.sv
// Arbiter sharing the example-slave register port between requester 0 and
// requester 1. One access at a time: IDLE (arbitrate + latch) -> ISSUE
// (strobe, capture read data) -> RESP (ack). All register-port outputs and
// acks are registered. Optional macro CMSDK_AHB_EG_SLAVE_ARB_FIXED_PRIO_EN
// switches the grant policy from round-robin to fixed priority (requester 0).
module cmsdk_ahb_eg_slave_arb
    import cmsdk_ahb_eg_slave_arb_pkg::*;
#(
    parameter int ADDRWIDTH = 12
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 req0,
    input  logic [ADDRWIDTH-1:0] addr0,
    input  logic                 write0,
    input  logic [3:0]           strb0,
    input  logic [31:0]          wdata0,
    input  logic                 req1,
    input  logic [ADDRWIDTH-1:0] addr1,
    input  logic                 write1,
    input  logic [3:0]           strb1,
    input  logic [31:0]          wdata1,
    output logic                 ack0,
    output logic [31:0]          rdata0,
    output logic                 ack1,
    output logic [31:0]          rdata1,
    output logic [ADDRWIDTH-1:0] reg_addr,
    output logic                 reg_read_en,
    output logic                 reg_write_en,
    output logic [3:0]           reg_byte_strobe,
    output logic [31:0]          reg_wdata,
    input  logic [31:0]          reg_rdata
);

    arb_state_t           state;
    arb_state_t           state_nxt;
    req_idx_t             gnt_idx;
    req_idx_t             win_idx;
    req_idx_t             win_nxt;
    logic                 any_req;
    logic                 grant_take;

    logic [ADDRWIDTH-1:0] sel_addr;
    logic                 sel_write;
    logic [3:0]           sel_strb;
    logic [31:0]          sel_wdata;

    logic [ADDRWIDTH-1:0] addr_nxt;
    logic                 read_en_nxt;
    logic                 write_en_nxt;
    logic [3:0]           strb_nxt;
    logic [31:0]          wdata_nxt;
    logic                 ack0_nxt;
    logic                 ack1_nxt;
    logic [31:0]          rdata0_nxt;
    logic [31:0]          rdata1_nxt;

    assign any_req    = req0 | req1;
    assign grant_take = (state == ST_IDLE) && any_req;

    assign sel_addr   = (gnt_idx == REQ_IDX_1) ? addr1  : addr0;
    assign sel_write  = (gnt_idx == REQ_IDX_1) ? write1 : write0;
    assign sel_strb   = (gnt_idx == REQ_IDX_1) ? strb1  : strb0;
    assign sel_wdata  = (gnt_idx == REQ_IDX_1) ? wdata1 : wdata0;

    cmsdk_ahb_eg_slave_arb_rr u_rr (
`ifndef CMSDK_AHB_EG_SLAVE_ARB_FIXED_PRIO_EN
        .hclk    (hclk),
        .hresetn (hresetn),
        .update  (grant_take),
`endif
        .req0    (req0),
        .req1    (req1),
        .gnt_idx (gnt_idx)
    );

    // State register; reset returns to IDLE and abandons any access in flight
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencing: IDLE waits for a request, ISSUE and RESP each last one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; port returns to idle values outside ISSUE
    always_comb begin
        addr_nxt     = '0;
        read_en_nxt  = REG_EN_DFLT;
        write_en_nxt = REG_EN_DFLT;
        strb_nxt     = REG_STRB_DFLT;
        wdata_nxt    = REG_WDATA_DFLT;
        ack0_nxt     = 1'b0;
        ack1_nxt     = 1'b0;
        rdata0_nxt   = rdata0;
        rdata1_nxt   = rdata1;
        win_nxt      = win_idx;
        case (state)
            ST_IDLE: begin
                if (grant_take) begin
                    win_nxt      = gnt_idx;
                    addr_nxt     = sel_addr;
                    read_en_nxt  = !sel_write;
                    write_en_nxt = sel_write;
                    strb_nxt     = sel_write ? sel_strb : REG_STRB_DFLT;
                    wdata_nxt    = sel_wdata;
                end
            end
            ST_ISSUE: begin
                if (win_idx == REQ_IDX_1) begin
                    ack1_nxt = 1'b1;
                    if (reg_read_en) rdata1_nxt = reg_rdata;
                end else begin
                    ack0_nxt = 1'b1;
                    if (reg_read_en) rdata0_nxt = reg_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    // Output registers; reset clears strobes, acks and captured read data together
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            win_idx         <= REQ_IDX_0;
            reg_addr        <= '0;
            reg_read_en     <= REG_EN_DFLT;
            reg_write_en    <= REG_EN_DFLT;
            reg_byte_strobe <= REG_STRB_DFLT;
            reg_wdata       <= REG_WDATA_DFLT;
            ack0            <= 1'b0;
            ack1            <= 1'b0;
            rdata0          <= RDATA_DFLT;
            rdata1          <= RDATA_DFLT;
        end else begin
            win_idx         <= win_nxt;
            reg_addr        <= addr_nxt;
            reg_read_en     <= read_en_nxt;
            reg_write_en    <= write_en_nxt;
            reg_byte_strobe <= strb_nxt;
            reg_wdata       <= wdata_nxt;
            ack0            <= ack0_nxt;
            ack1            <= ack1_nxt;
            rdata0          <= rdata0_nxt;
            rdata1          <= rdata1_nxt;
        end
    end

endmodule

// File: tb/tb_cmsdk_ahb_eg_slave_arb.sv
// Self-checking bench for cmsdk_ahb_eg_slave_arb: directed scenarios with
// literal expectations followed by randomized traffic, all outputs compared
// every cycle against a transaction-level model of the arbiter.
module tb_cmsdk_ahb_eg_slave_arb;

    logic        hclk;
    logic        hresetn;
    logic        req0, req1;
    logic [11:0] addr0, addr1;
    logic        write0, write1;
    logic [3:0]  strb0, strb1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [11:0] reg_addr;
    logic        reg_read_en, reg_write_en;
    logic [3:0]  reg_byte_strobe;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] slave_mem [8];

    cmsdk_ahb_eg_slave_arb #(.ADDRWIDTH(12)) dut (
        .hclk            (hclk),
        .hresetn         (hresetn),
        .req0            (req0),
        .addr0           (addr0),
        .write0          (write0),
        .strb0           (strb0),
        .wdata0          (wdata0),
        .req1            (req1),
        .addr1           (addr1),
        .write1          (write1),
        .strb1           (strb1),
        .wdata1          (wdata1),
        .ack0            (ack0),
        .rdata0          (rdata0),
        .ack1            (ack1),
        .rdata1          (rdata1),
        .reg_addr        (reg_addr),
        .reg_read_en     (reg_read_en),
        .reg_write_en    (reg_write_en),
        .reg_byte_strobe (reg_byte_strobe),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Cycle counter: value k holds between rising edges k and k+1
    always @(posedge hclk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'h1234_5678 : (32'hA500_0000 | (32'(i) * 32'h0001_0101));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Register block stand-in: combinational read, byte-strobed write
    assign reg_rdata = reg_read_en ? slave_mem[reg_addr[4:2]] : 32'h0;

    always @(posedge hclk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 8; i++) slave_mem[i] <= init_word(i);
        end else if (reg_write_en) begin
            slave_mem[reg_addr[4:2]] <= merge(slave_mem[reg_addr[4:2]], reg_wdata, reg_byte_strobe);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic req, input logic [11:0] addr,
                                 input logic wr, input logic [3:0] strb, input logic [31:0] wd);
        if (idx == 0) begin
            req0 = req; addr0 = addr; write0 = wr; strb0 = strb; wdata0 = wd;
        end else begin
            req1 = req; addr1 = addr; write1 = wr; strb1 = strb; wdata1 = wd;
        end
    endtask

    // Transaction-level model: one access per grant, strobes one cycle after
    // the grant, ack two cycles after, next grant no earlier than three after
    initial begin : model
        int          c;
        int          free_at;
        bit          tr_valid;
        int          tr_win;
        bit          tr_write;
        logic [11:0] tr_addr;
        logic [3:0]  tr_strb;
        logic [31:0] tr_wdata;
        logic [31:0] tr_rval;
        int          tr_issue;
        int          rr_last;
        bit          issue_now;
        bit          ack_now;
        int          win;
        logic [31:0] model_mem [8];
        logic [31:0] exp_rd [2];

        free_at  = 0;
        tr_valid = 0;
        tr_win   = 0;
        tr_write = 0;
        tr_addr  = '0;
        tr_strb  = '0;
        tr_wdata = '0;
        tr_rval  = '0;
        tr_issue = 0;
        rr_last  = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        for (int i = 0; i < 8; i++) model_mem[i] = init_word(i);

        forever begin
            @(negedge hclk);
            if (cyc >= 1) begin
                c = cyc;
                issue_now = tr_valid && (c == tr_issue);
                ack_now   = tr_valid && (c == tr_issue + 1);
                if (ack_now && !tr_write) exp_rd[tr_win] = tr_rval;

                checkOutput("m_read_en",  32'(reg_read_en),     32'(issue_now && !tr_write));
                checkOutput("m_write_en", 32'(reg_write_en),    32'(issue_now && tr_write));
                checkOutput("m_strobe",   32'(reg_byte_strobe), (issue_now && tr_write) ? 32'(tr_strb) : 32'h0);
                checkOutput("m_addr",     32'(reg_addr),        issue_now ? 32'(tr_addr) : 32'h0);
                checkOutput("m_wdata",    reg_wdata,            issue_now ? tr_wdata : 32'h0);
                checkOutput("m_ack0",     32'(ack0),            32'(ack_now && tr_win == 0));
                checkOutput("m_ack1",     32'(ack1),            32'(ack_now && tr_win == 1));
                checkOutput("m_rdata0",   rdata0,               exp_rd[0]);
                checkOutput("m_rdata1",   rdata1,               exp_rd[1]);

                if (issue_now) begin
                    if (tr_write) model_mem[tr_addr[4:2]] = merge(model_mem[tr_addr[4:2]], tr_wdata, tr_strb);
                    else          tr_rval = model_mem[tr_addr[4:2]];
                end

                if (!hresetn) begin
                    tr_valid  = 0;
                    exp_rd[0] = '0;
                    exp_rd[1] = '0;
                    rr_last   = 1;
                    free_at   = c + 1;
                end else if (c >= free_at && (req0 || req1)) begin
                    if (req0 && req1) begin
`ifdef CMSDK_AHB_EG_SLAVE_ARB_FIXED_PRIO_EN
                        win = 0;
`else
                        win = (rr_last == 0) ? 1 : 0;
`endif
                    end else begin
                        win = req1 ? 1 : 0;
                    end
                    rr_last  = win;
                    tr_valid = 1;
                    tr_win   = win;
                    tr_write = (win == 1) ? write1 : write0;
                    tr_addr  = (win == 1) ? addr1  : addr0;
                    tr_strb  = (win == 1) ? strb1  : strb0;
                    tr_wdata = (win == 1) ? wdata1 : wdata0;
                    tr_issue = c + 1;
                    free_at  = c + 3;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        fails++;
        $display("[TB] FAIL watchdog: time limit reached without finishing, required completion");
        $fatal(1, "[TB] aborted by watchdog");
    end

    initial begin : stim
        int   ack_t[$];
        int   ack_w[$];
        int   exp_order[4];
        int   a0t, a1t;
        bit   p0, p1;
        logic s0, s1;

`ifdef CMSDK_AHB_EG_SLAVE_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif

        hresetn = 1'b0;
        applyStimulus(0, 1'b0, 12'h0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 12'h0, 1'b0, 4'h0, 32'h0);

        // Reset state
        @(negedge hclk);
        checkOutput("rst_ack0",     32'(ack0), 32'h0);
        checkOutput("rst_ack1",     32'(ack1), 32'h0);
        checkOutput("rst_read_en",  32'(reg_read_en), 32'h0);
        checkOutput("rst_write_en", 32'(reg_write_en), 32'h0);
        checkOutput("rst_rdata0",   rdata0, 32'h0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // Single read by requester 0
        applyStimulus(0, 1'b1, 12'h004, 1'b0, 4'hF, 32'h0);
        @(negedge hclk);
        checkOutput("rd_n_read_en", 32'(reg_read_en), 32'h0);
        @(negedge hclk);
        checkOutput("rd_n1_read_en",  32'(reg_read_en), 32'h1);
        checkOutput("rd_n1_write_en", 32'(reg_write_en), 32'h0);
        checkOutput("rd_n1_addr",     32'(reg_addr), 32'h004);
        checkOutput("rd_n1_strobe",   32'(reg_byte_strobe), 32'h0);
        @(negedge hclk);
        checkOutput("rd_n2_ack0",   32'(ack0), 32'h1);
        checkOutput("rd_n2_ack1",   32'(ack1), 32'h0);
        checkOutput("rd_n2_rdata0", rdata0, 32'h1234_5678);
        @(posedge hclk); #1;
        applyStimulus(0, 1'b0, 12'h004, 1'b0, 4'hF, 32'h0);

        // Byte write by requester 1
        applyStimulus(1, 1'b1, 12'h008, 1'b1, 4'b0101, 32'hAABB_CCDD);
        @(negedge hclk);
        @(negedge hclk);
        checkOutput("wr_n1_write_en", 32'(reg_write_en), 32'h1);
        checkOutput("wr_n1_read_en",  32'(reg_read_en), 32'h0);
        checkOutput("wr_n1_strobe",   32'(reg_byte_strobe), 32'h5);
        checkOutput("wr_n1_wdata",    reg_wdata, 32'hAABB_CCDD);
        @(negedge hclk);
        checkOutput("wr_n2_ack1",     32'(ack1), 32'h1);
        checkOutput("wr_n2_write_en", 32'(reg_write_en), 32'h0);
        checkOutput("wr_n2_rdata1",   rdata1, 32'h0);
        @(posedge hclk); #1;
        applyStimulus(1, 1'b0, 12'h008, 1'b1, 4'b0101, 32'hAABB_CCDD);

        // Contention: both held high for four accesses
        applyStimulus(0, 1'b1, 12'h010, 1'b0, 4'h0, 32'h0);
        applyStimulus(1, 1'b1, 12'h014, 1'b0, 4'h0, 32'h0);
        for (int t = 0; t < 12; t++) begin
            if (t > 0) begin
                @(posedge hclk); #1;
            end
            @(negedge hclk);
            if (ack0) begin ack_t.push_back(t); ack_w.push_back(0); end
            if (ack1) begin ack_t.push_back(t); ack_w.push_back(1); end
        end
        @(posedge hclk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        checkOutput("cont_ack_count", 32'(ack_t.size()), 32'd4);
        for (int k = 0; k < ack_t.size() && k < 4; k++) begin
            checkOutput("cont_ack_cycle", 32'(ack_t[k]), 32'(2 + 3 * k));
            checkOutput("cont_ack_owner", 32'(ack_w[k]), 32'(exp_order[k]));
        end

        // Late arrival of requester 1 during requester 0's ISSUE cycle
        a0t = -1;
        a1t = -1;
        applyStimulus(0, 1'b1, 12'h000, 1'b0, 4'h0, 32'h0);
        for (int t = 0; t < 8; t++) begin
            if (t > 0) begin
                @(posedge hclk); #1;
            end
            if (t == 1) applyStimulus(1, 1'b1, 12'h004, 1'b0, 4'h0, 32'h0);
            if (t == 3) req0 = 1'b0;
            if (t == 6) req1 = 1'b0;
            @(negedge hclk);
            if (ack0 && a0t < 0) a0t = t;
            if (ack1 && a1t < 0) a1t = t;
        end
        @(posedge hclk); #1;
        checkOutput("late_ack0_cycle", 32'(a0t), 32'd2);
        checkOutput("late_ack1_cycle", 32'(a1t), 32'd5);

        // Reset during the ISSUE cycle of a write
        applyStimulus(0, 1'b1, 12'h018, 1'b1, 4'hF, 32'h0000_0055);
        @(negedge hclk);
        @(posedge hclk); #1;
        hresetn = 1'b0;
        @(negedge hclk);
        checkOutput("rstmid_issue_wr", 32'(reg_write_en), 32'h1);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        applyStimulus(0, 1'b1, 12'h000, 1'b0, 4'h0, 32'h0);
        applyStimulus(1, 1'b1, 12'h004, 1'b0, 4'h0, 32'h0);
        @(negedge hclk);
        checkOutput("rstmid_write_en", 32'(reg_write_en), 32'h0);
        checkOutput("rstmid_read_en",  32'(reg_read_en), 32'h0);
        checkOutput("rstmid_strobe",   32'(reg_byte_strobe), 32'h0);
        checkOutput("rstmid_addr",     32'(reg_addr), 32'h0);
        checkOutput("rstmid_wdata",    reg_wdata, 32'h0);
        checkOutput("rstmid_ack0",     32'(ack0), 32'h0);
        checkOutput("rstmid_rdata0",   rdata0, 32'h0);
        @(negedge hclk);
        checkOutput("rstmid_gnt_read_en", 32'(reg_read_en), 32'h1);
        checkOutput("rstmid_gnt_addr",    32'(reg_addr), 32'h000);
        @(negedge hclk);
        checkOutput("rstmid_first_ack0", 32'(ack0), 32'h1);
        checkOutput("rstmid_first_ack1", 32'(ack1), 32'h0);
        @(posedge hclk); #1;
        req0 = 1'b0;
        @(negedge hclk);
        @(negedge hclk);
        @(negedge hclk);
        checkOutput("rstmid_second_ack1", 32'(ack1), 32'h1);
        checkOutput("rstmid_rdata1",      rdata1, 32'h1234_5678);
        @(posedge hclk); #1;
        req1 = 1'b0;

        // Write via requester 0, read back via requester 1
        applyStimulus(0, 1'b1, 12'h00C, 1'b1, 4'hF, 32'hDEAD_BEEF);
        @(negedge hclk);
        @(negedge hclk);
        @(negedge hclk);
        checkOutput("rb_wr_ack0", 32'(ack0), 32'h1);
        @(posedge hclk); #1;
        req0 = 1'b0;
        applyStimulus(1, 1'b1, 12'h00C, 1'b0, 4'h0, 32'h0);
        @(negedge hclk);
        @(negedge hclk);
        @(negedge hclk);
        checkOutput("rb_rd_ack1",   32'(ack1), 32'h1);
        checkOutput("rb_rd_rdata1", rdata1, 32'hDEAD_BEEF);
        @(posedge hclk); #1;
        req1 = 1'b0;

        // Randomized traffic with occasional resets; model checks every cycle
        p0 = 0;
        p1 = 0;
        s0 = 1'b0;
        s1 = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge hclk); #1;
            hresetn = ($urandom_range(0, 249) != 0);
            if (p0 && s0) p0 = 0;
            if (p1 && s1) p1 = 0;
            if (!p0 && $urandom_range(0, 2) == 0) begin
                p0 = 1;
                applyStimulus(0, 1'b1, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                              4'($urandom_range(0, 15)), $urandom);
            end
            if (!p1 && $urandom_range(0, 2) == 0) begin
                p1 = 1;
                applyStimulus(1, 1'b1, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                              4'($urandom_range(0, 15)), $urandom);
            end
            req0 = p0;
            req1 = p1;
            @(negedge hclk);
            s0 = ack0;
            s1 = ack1;
        end

        @(posedge hclk); #1;
        hresetn = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(negedge hclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
